id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_detection.sv | 33 +++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings and the ID/EX control bundle
package cpu_pkg;

  localparam logic [1:0] ALU_R = 2'b00;
  localparam logic [1:0] ALU_I = 2'b01;
  localparam logic [1:0] ALU_S = 2'b10;
  localparam logic [1:0] ALU_B = 2'b11;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } id_ex_ctrl_t;

endpackage

// File: rtl/hazard_detection.sv
// rtl/hazard_detection.sv - load-use hazard detection and saturating stall counter
module hazard_detection #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rd,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   flush,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic hazard;

  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall  = hazard & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register; load-use stalls under HAZARD_DETECT_EN
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [1:0]             ALUOp_i,
  input  logic                   ALUSrc_i,
  input  logic                   RegWrite_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic                   MemToReg_i,
  input  logic [31:0]            RS1data_i,
  input  logic [31:0]            RS2data_i,
  input  logic [31:0]            Imm_i,
  input  logic [9:0]             funct_i,
  input  logic [4:0]             RS1addr_i,
  input  logic [4:0]             RS2addr_i,
  input  logic [4:0]             RDaddr_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  output logic [1:0]             ALUOp_o,
  output logic                   ALUSrc_o,
  output logic                   RegWrite_o,
  output logic                   MemRead_o,
  output logic                   MemWrite_o,
  output logic                   MemToReg_o,
  output logic [31:0]            RS1data_o,
  output logic [31:0]            RS2data_o,
  output logic [31:0]            Imm_o,
  output logic [9:0]             funct_o,
  output logic [4:0]             RS1addr_o,
  output logic [4:0]             RS2addr_o,
  output logic [4:0]             RDaddr_o,
  output logic                   stall_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  id_ex_ctrl_t ctrl_in;
  id_ex_ctrl_t ctrl_q;
  logic        stall;

  assign ctrl_in = '{alu_op: ALUOp_i, alu_src: ALUSrc_i, reg_write: RegWrite_i,
                     mem_read: MemRead_i, mem_write: MemWrite_i, mem_to_reg: MemToReg_i};

`ifdef HAZARD_DETECT_EN
  hazard_detection #(
    .STALL_CNT_W(STALL_CNT_W)
  ) u_hazard (
    .clk        (clk_i),
    .rst        (rst_i),
    .ex_valid   (valid_o),
    .ex_mem_read(ctrl_q.mem_read),
    .ex_rd      (RDaddr_o),
    .id_valid   (valid_i),
    .id_rs1     (RS1addr_i),
    .id_rs2     (RS2addr_i),
    .flush      (flush_i),
    .stall      (stall),
    .stall_cnt  (stall_cnt_o)
  );
`else
  assign stall       = 1'b0;
  assign stall_cnt_o = '0;
`endif

  assign stall_o = stall;

  // Flush and stall both insert a fully zeroed bubble; flush wins because stall is masked by it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      ctrl_q    <= '0;
      RS1data_o <= '0;
      RS2data_o <= '0;
      Imm_o     <= '0;
      funct_o   <= '0;
      RS1addr_o <= '0;
      RS2addr_o <= '0;
      RDaddr_o  <= '0;
    end else if (flush_i || stall) begin
      valid_o   <= 1'b0;
      ctrl_q    <= '0;
      RS1data_o <= '0;
      RS2data_o <= '0;
      Imm_o     <= '0;
      funct_o   <= '0;
      RS1addr_o <= '0;
      RS2addr_o <= '0;
      RDaddr_o  <= '0;
    end else begin
      valid_o   <= valid_i;
      ctrl_q    <= valid_i ? ctrl_in : '0;
      RS1data_o <= RS1data_i;
      RS2data_o <= RS2data_i;
      Imm_o     <= Imm_i;
      funct_o   <= funct_i;
      RS1addr_o <= RS1addr_i;
      RS2addr_o <= RS2addr_i;
      RDaddr_o  <= RDaddr_i;
    end
  end

  assign ALUOp_o    = ctrl_q.alu_op;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign RegWrite_o = ctrl_q.reg_write;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign MemToReg_o = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage (both HAZARD_DETECT_EN builds)
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemToReg_i, flush_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

  logic        valid_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o, stall_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic [15:0] stall_cnt_o;

  logic        s_valid, s_alusrc, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_stall;
  logic [1:0]  s_aluop;
  logic [31:0] s_rs1data, s_rs2data, s_imm;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_sat = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.STALL_CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemToReg_i(MemToReg_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .flush_i(flush_i),
    .valid_o(valid_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemToReg_o(MemToReg_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  id_ex_stage #(.STALL_CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemToReg_i(MemToReg_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .flush_i(flush_i),
    .valid_o(s_valid), .ALUOp_o(s_aluop), .ALUSrc_o(s_alusrc), .RegWrite_o(s_regwrite),
    .MemRead_o(s_memread), .MemWrite_o(s_memwrite), .MemToReg_o(s_memtoreg),
    .RS1data_o(s_rs1data), .RS2data_o(s_rs2data), .Imm_o(s_imm), .funct_o(s_funct),
    .RS1addr_o(s_rs1), .RS2addr_o(s_rs2), .RDaddr_o(s_rd),
    .stall_o(s_stall), .stall_cnt_o(s_stall_cnt)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_id();
    valid_i = 1'b0; ALUOp_i = ALU_R; ALUSrc_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0;
    MemWrite_i = 1'b0; MemToReg_i = 1'b0; RS1data_i = '0; RS2data_i = '0; Imm_i = '0;
    funct_i = '0; RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0; flush_i = 1'b0;
  endtask

  task automatic put_load(input logic [4:0] rd);
    clear_id();
    valid_i = 1'b1; ALUOp_i = ALU_I; ALUSrc_i = 1'b1; RegWrite_i = 1'b1;
    MemRead_i = 1'b1; MemToReg_i = 1'b1; RDaddr_i = rd; RS1addr_i = 5'd1; RS2addr_i = 5'd2;
  endtask

  task automatic put_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    clear_id();
    valid_i = 1'b1; ALUOp_i = ALU_R; RegWrite_i = 1'b1;
    RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = 5'd6; Imm_i = imm;
  endtask

  task automatic count_stall_edge();
    exp_cnt += HAZ;
    exp_sat = (exp_sat + HAZ > 3) ? 3 : exp_sat + HAZ;
  endtask

  task automatic test_reset();
    clear_id();
    rst_i = 1'b1;
    step(); step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", valid_o); end
    checks++; if (RS1data_o !== 32'd0) begin errors++; $display("FAIL reset_rs1data: got %0h want 0", RS1data_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", stall_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", stall_cnt_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_alu_capture();
    clear_id();
    valid_i = 1'b1; ALUOp_i = ALU_I; ALUSrc_i = 1'b1; RegWrite_i = 1'b1;
    RS1data_i = 32'h0000_0005; Imm_i = 32'h0000_000A; RDaddr_i = 5'd3; funct_i = 10'h2A5;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0h want 0", stall_o); end
    step();
    checks++; if (RS1data_o !== 32'd5) begin errors++; $display("FAIL alu_rs1data: got %0h want 5", RS1data_o); end
    checks++; if (Imm_o !== 32'hA) begin errors++; $display("FAIL alu_imm: got %0h want a", Imm_o); end
    checks++; if (ALUSrc_o !== 1'b1) begin errors++; $display("FAIL alu_alusrc: got %0h want 1", ALUSrc_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid: got %0h want 1", valid_o); end
    checks++; if (ALUOp_o !== 2'b01) begin errors++; $display("FAIL alu_aluop: got %0h want 1", ALUOp_o); end
    checks++; if (funct_o !== 10'h2A5) begin errors++; $display("FAIL alu_funct: got %0h want 2a5", funct_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall_after: got %0h want 0", stall_o); end
  endtask

  task automatic test_load_use();
    put_load(5'd5);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_no_stall_on_load: got %0h want 0", stall_o); end
    step();
    checks++; if (MemRead_o !== 1'b1) begin errors++; $display("FAIL lu_load_in_ex: got %0h want 1", MemRead_o); end
    put_add(5'd7, 5'd5, 32'h0);
    #1;
    checks++; if (stall_o !== HAZ) begin errors++; $display("FAIL lu_stall: got %0h want %0h", stall_o, HAZ); end
    step();
    count_stall_edge();
    checks++; if (valid_o !== !HAZ) begin errors++; $display("FAIL lu_valid: got %0h want %0h", valid_o, !HAZ); end
    checks++; if (MemRead_o !== 1'b0) begin errors++; $display("FAIL lu_memread: got %0h want 0", MemRead_o); end
    checks++; if (RS2addr_o !== (HAZ ? 5'd0 : 5'd5)) begin errors++; $display("FAIL lu_rs2addr: got %0h want %0h", RS2addr_o, HAZ ? 5'd0 : 5'd5); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_cleared: got %0h want 0", stall_o); end
    checks++; if (stall_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt_o, exp_cnt); end
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL lu_replay_valid: got %0h want 1", valid_o); end
  endtask

  task automatic test_x0_load();
    put_load(5'd0);
    step();
    put_add(5'd0, 5'd3, 32'h55);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0h want 0", stall_o); end
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL x0_valid: got %0h want 1", valid_o); end
    checks++; if (Imm_o !== 32'h55) begin errors++; $display("FAIL x0_imm: got %0h want 55", Imm_o); end
    checks++; if (stall_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL x0_cnt: got %0d want %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_flush_priority();
    put_load(5'd5);
    step();
    put_add(5'd5, 5'd9, 32'h77);
    flush_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", stall_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0h want 0", valid_o); end
    checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL flush_regwrite: got %0h want 0", RegWrite_o); end
    checks++; if (Imm_o !== 32'h0) begin errors++; $display("FAIL flush_imm: got %0h want 0", Imm_o); end
    checks++; if (RS1addr_o !== 5'd0) begin errors++; $display("FAIL flush_rs1addr: got %0h want 0", RS1addr_o); end
    checks++; if (stall_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt_o, exp_cnt); end
    flush_i = 1'b0;
  endtask

  task automatic test_invalid_id();
    clear_id();
    RegWrite_i = 1'b1; MemRead_i = 1'b1; RS1data_i = 32'h1234; RDaddr_i = 5'd4;
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL inv_valid: got %0h want 0", valid_o); end
    checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL inv_regwrite: got %0h want 0", RegWrite_o); end
    checks++; if (MemRead_o !== 1'b0) begin errors++; $display("FAIL inv_memread: got %0h want 0", MemRead_o); end
    checks++; if (RS1data_o !== 32'h1234) begin errors++; $display("FAIL inv_rs1data: got %0h want 1234", RS1data_o); end
    checks++; if (RDaddr_o !== 5'd4) begin errors++; $display("FAIL inv_rdaddr: got %0h want 4", RDaddr_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      put_load(5'd5);
      step();
      put_add(5'd5, 5'd8, 32'h0);
      #1;
      checks++; if (stall_o !== HAZ) begin errors++; $display("FAIL sat_stall_%0d: got %0h want %0h", i, stall_o, HAZ); end
      step();
      count_stall_edge();
      checks++; if (s_stall_cnt !== 2'(exp_sat)) begin errors++; $display("FAIL sat_cnt2_%0d: got %0d want %0d", i, s_stall_cnt, exp_sat); end
    end
    checks++; if (s_stall_cnt !== (HAZ ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_final: got %0d want %0d", s_stall_cnt, HAZ ? 3 : 0); end
    checks++; if (stall_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_cnt16: got %0d want %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    put_load(5'd5);
    step();
    put_add(5'd5, 5'd2, 32'h99);
    #1;
    checks++; if (stall_o !== HAZ) begin errors++; $display("FAIL rms_stall_before: got %0h want %0h", stall_o, HAZ); end
    rst_i = 1'b1;
    #1;
    exp_cnt = 0;
    exp_sat = 0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rms_valid: got %0h want 0", valid_o); end
    checks++; if (MemRead_o !== 1'b0) begin errors++; $display("FAIL rms_memread: got %0h want 0", MemRead_o); end
    checks++; if (RDaddr_o !== 5'd0) begin errors++; $display("FAIL rms_rdaddr: got %0h want 0", RDaddr_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0h want 0", stall_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt_o); end
    checks++; if (s_stall_cnt !== 2'd0) begin errors++; $display("FAIL rms_cnt2: got %0d want 0", s_stall_cnt); end
    rst_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rms_stall_after: got %0h want 0", stall_o); end
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rms_capture_valid: got %0h want 1", valid_o); end
    checks++; if (Imm_o !== 32'h99) begin errors++; $display("FAIL rms_capture_imm: got %0h want 99", Imm_o); end
    checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rms_cnt_after: got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms [3];
    imms[0] = 32'h1111_0001; imms[1] = 32'h2222_0002; imms[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      put_add(5'(i + 10), 5'(i + 20), imms[i]);
      MemWrite_i = i[0];
      step();
      checks++; if (Imm_o !== imms[i]) begin errors++; $display("FAIL b2b_imm_%0d: got %0h want %0h", i, Imm_o, imms[i]); end
      checks++; if (RS2addr_o !== 5'(i + 20)) begin errors++; $display("FAIL b2b_rs2_%0d: got %0h want %0h", i, RS2addr_o, i + 20); end
      checks++; if (MemWrite_o !== i[0]) begin errors++; $display("FAIL b2b_memwrite_%0d: got %0h want %0h", i, MemWrite_o, i[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_capture();
    test_load_use();
    test_x0_load();
    test_flush_priority();
    test_invalid_id();
    test_saturation();
    test_reset_mid_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
